// File: rtl/serial_adder_if.sv
// Operand/result bundle between an operand source, the serial adder and its result consumer.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, registered carry between bits.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             fa_s;
   logic             fa_c;
   logic [WIDTH-1:0] sum_shifted;
   logic             accept;

   // The single full-adder cell, fed from the operand LSBs and the carry flop.
   assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
   assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

   // New sum bit enters at the MSB so that after WIDTH steps bit 0 holds the LSB.
   generate
      for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_sum_shift
         assign sum_shifted[gi] = sum_sh_q[gi+1];
      end
   endgenerate
   assign sum_shifted[WIDTH-1] = fa_s;

   // A start is only honoured when not busy: in IDLE or in the DONE cycle.
   assign accept = bus.start && (state_q != SHIFT);

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            sum_sh_d = sum_shifted;
            carry_d  = fa_c;
            if (cnt_q == LAST_BIT) begin
               sum_d   = sum_shifted;
               cout_d  = fa_c;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
      end
   end

   // Status is decoded from the state register, so busy and done are mutually exclusive.
   assign bus.busy = (state_q == SHIFT);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around the single full-adder cell: one full-adder evaluation per clock, with a registered carry between bits. It sits directly upstream of result consumers and downstream of operand sources, and is the sequential wrapper the standalone full adder needs to add multi-bit words. Operands are captured on a start pulse. The sum is produced LSB-first into a shift register, and completion is reported with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  registered result, valid from the done cycle until the next accepted start.
- cout  output  1  registered final carry, same validity as sum.

## Operation
- Reset (rst_n low at a rising edge) returns the block to IDLE and drives outputs as follows:
  - busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry flop and bit counter are all cleared.
  - Reset takes effect even in the middle of an operation; the partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1, latch a→A_sh, b→B_sh, cin→carry, count=0, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each cycle, compute s = A_sh[0]^B_sh[0]^carry and c = majority(A_sh[0], B_sh[0], carry).
  - Shift A_sh and B_sh right by one.
  - Shift s into sum_sh at the MSB (sum_sh = {s, sum_sh[WIDTH-1:1]}), set carry=c, and increment count.
  - When count==WIDTH-1 in this cycle, go to DONE; sum and cout load from the final sum_sh and c at that same edge.
- DONE:
  - done=1 for exactly one cycle.
  - If start=1 in this cycle, it is accepted as in IDLE (go to SHIFT). Otherwise go to IDLE.
- start while busy=1 is ignored entirely: no latch, no queueing.
- sum/cout hold the last result through IDLE. They are overwritten only at the completion edge of the next operation.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1); overflow appears only through cout.
- The counter is $clog2(WIDTH) bits and never wraps inside an operation.

## Timing
- Edge 0: start is sampled high in IDLE. busy rises after edge 0.
- Edges 1..WIDTH: one bit is processed per edge, LSB first.
- sum/cout update at edge WIDTH. At that same edge done rises and busy falls.
- done is high for the single cycle between edges WIDTH and WIDTH+1.
- Latency from start-sample edge to done=1 is WIDTH cycles. Throughput is one operation per WIDTH+1 cycles; back-to-back start during DONE gives a gap of 1 cycle.
- busy and done are never high together.
- a, b and cin may change freely after the start edge without affecting the result.

## Test plan
- Reset, then idle → busy=0, done=0, sum=0x00, cout=0. With WIDTH=8, a=0x00, b=0x00, cin=0 and start pulsed → done exactly 8 cycles after the start edge with sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1. a=0x3C, b=0x42, cin=0 → sum=0x7E, cout=0.
- All 8 {a[0], b[0], cin} combinations with upper bits zero (full-adder truth table) → sum[0] and sum[1] match the full-adder sum and carry for every vector, cout=0.
- start=1 held for 5 cycles while busy, with a and b changed mid-operation → only the first operands are used; exactly one done pulse.
- start asserted in the DONE cycle with new operands 0x10+0x20 → second done 8 cycles later with sum=0x30, and the first result holds until then.
- rst_n=0 for one edge at bit 4 of 0xFF+0xFF → all outputs 0 next cycle, no done pulse, state IDLE. A subsequent 0x01+0x01 gives sum=0x02.
